// File: rtl/retire_rrat_if.sv
// ROB-head bus between the reorder buffer (master) and the retire stage (slave).
interface retire_rrat_if #(
   parameter int PHYS_W = 6
);
   logic              rob_head_valid;
   logic              rob_head_done;
   logic              rob_head_regwr;
   logic [4:0]        rob_head_archreg;
   logic [PHYS_W-1:0] rob_head_physreg;
   logic              rob_head_mispredict;
   logic [31:0]       rob_head_target;
   logic              rob_retire;

   modport master (
      output rob_head_valid, rob_head_done, rob_head_regwr, rob_head_archreg,
             rob_head_physreg, rob_head_mispredict, rob_head_target,
      input  rob_retire
   );

   modport slave (
      input  rob_head_valid, rob_head_done, rob_head_regwr, rob_head_archreg,
             rob_head_physreg, rob_head_mispredict, rob_head_target,
      output rob_retire
   );
endinterface

// File: rtl/retire_rrat.sv
// In-order retire stage: commits the ROB head, maintains the retirement RAT,
// returns superseded physical registers to the free list and raises a flush
// on a mispredicted head, then holds off commits while the front end rebuilds.
module retire_rrat #(
   parameter int PHYS_W     = 6,
   parameter int FLUSH_HOLD = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              STALL,
   retire_rrat_if.slave      rob,
   output logic [PHYS_W-1:0] rrat_map [32],
   output logic              rrat_free,
   output logic [PHYS_W-1:0] rrat_free_reg,
   output logic              FLUSH,
   output logic [31:0]       flush_pc,
   output logic [31:0]       retired_count
);

   typedef enum logic {
      RUN,
      HOLD
   } state_t;

   localparam logic [3:0] HOLD_INIT = 4'(FLUSH_HOLD);

   state_t            state;
   logic [3:0]        hold_cnt;
   logic              commit;
   logic              do_free;
   logic [PHYS_W-1:0] old_phys;

   // Commit decision and lookup of the mapping about to be superseded
   always_comb begin
      commit   = (state == RUN) && !STALL && rob.rob_head_valid && rob.rob_head_done;
      old_phys = rrat_map[rob.rob_head_archreg];
      do_free  = commit && rob.rob_head_regwr && (rob.rob_head_archreg != '0)
                 && (rob.rob_head_physreg != old_phys);
   end

   assign rob.rob_retire = commit;

   // Retirement RAT: identity map out of reset, updated by each freeing commit
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int unsigned i = 0; i < 32; i++) begin
            rrat_map[i] <= PHYS_W'(i);
         end
      end else if (do_free) begin
         rrat_map[rob.rob_head_archreg] <= rob.rob_head_physreg;
      end
   end

   // Free-list return pulse and committed-instruction counter
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rrat_free     <= 1'b0;
         rrat_free_reg <= '0;
         retired_count <= '0;
      end else begin
         rrat_free <= do_free;
         if (do_free) begin
            rrat_free_reg <= old_phys;
         end
         if (commit) begin
            retired_count <= retired_count + 32'd1;
         end
      end
   end

   // Flush sequencing: one-cycle FLUSH pulse, then a stall-aware hold countdown
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state    <= RUN;
         hold_cnt <= '0;
         FLUSH    <= 1'b0;
         flush_pc <= '0;
      end else begin
         FLUSH <= 1'b0;
         case (state)
            RUN: begin
               if (commit && rob.rob_head_mispredict) begin
                  FLUSH    <= 1'b1;
                  flush_pc <= rob.rob_head_target;
                  state    <= HOLD;
                  hold_cnt <= HOLD_INIT;
               end
            end
            HOLD: begin
               // Leaving on the edge that consumes the last count gives exactly
               // FLUSH_HOLD non-stalled cycles without commit.
               if (!STALL) begin
                  if (hold_cnt <= 4'd1) begin
                     hold_cnt <= '0;
                     state    <= RUN;
                  end else begin
                     hold_cnt <= hold_cnt - 4'd1;
                  end
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_retire_rrat.sv
// Scoreboard bench for retire_rrat: each stimulus cycle pushes its
// hand-computed expectations; a monitor pops and compares on the falling edge.
module tb_retire_rrat;

   localparam int PHYS_W = 6;

   typedef struct {
      bit          retire;
      bit          free;
      logic [5:0]  free_reg;
      bit          flush;
      logic [31:0] pc;
      logic [31:0] count;
      int          map_idx;
      logic [5:0]  map_val;
   } exp_t;

   logic              clk;
   logic              RESET;
   logic              STALL;
   logic [PHYS_W-1:0] rrat_map [32];
   logic              rrat_free;
   logic [PHYS_W-1:0] rrat_free_reg;
   logic              FLUSH;
   logic [31:0]       flush_pc;
   logic [31:0]       retired_count;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   retire_rrat_if #(.PHYS_W(PHYS_W)) rob_if ();

   retire_rrat #(.PHYS_W(PHYS_W), .FLUSH_HOLD(2)) dut (
      .CLK           (clk),
      .RESET         (RESET),
      .STALL         (STALL),
      .rob           (rob_if.slave),
      .rrat_map      (rrat_map),
      .rrat_free     (rrat_free),
      .rrat_free_reg (rrat_free_reg),
      .FLUSH         (FLUSH),
      .flush_pc      (flush_pc),
      .retired_count (retired_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one scoreboard entry per cycle, compared away from the clock edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rob_retire", 32'(rob_if.rob_retire), 32'(e.retire));
            chk("rrat_free", 32'(rrat_free), 32'(e.free));
            chk("rrat_free_reg", 32'(rrat_free_reg), 32'(e.free_reg));
            chk("FLUSH", 32'(FLUSH), 32'(e.flush));
            if (e.flush) chk("flush_pc", flush_pc, e.pc);
            chk("retired_count", retired_count, e.count);
            if (e.map_idx >= 0) chk($sformatf("rrat_map[%0d]", e.map_idx), 32'(rrat_map[e.map_idx]), 32'(e.map_val));
         end
      end
   end

   // Drive one cycle of head/stall inputs and queue what the outputs must show in it
   task automatic step(input bit v, input bit d, input bit rw, input int arch, input int phys,
                       input bit mis, input logic [31:0] tgt, input bit stall,
                       input bit e_ret, input bit e_free, input int e_freg, input bit e_flush,
                       input logic [31:0] e_pc, input int e_cnt, input int m_idx, input int m_val);
      exp_t e;
      @(posedge clk);
      #1;
      rob_if.rob_head_valid      = v;
      rob_if.rob_head_done       = d;
      rob_if.rob_head_regwr      = rw;
      rob_if.rob_head_archreg    = 5'(arch);
      rob_if.rob_head_physreg    = 6'(phys);
      rob_if.rob_head_mispredict = mis;
      rob_if.rob_head_target     = tgt;
      STALL                      = stall;
      e.retire   = e_ret;
      e.free     = e_free;
      e.free_reg = 6'(e_freg);
      e.flush    = e_flush;
      e.pc       = e_pc;
      e.count    = 32'(e_cnt);
      e.map_idx  = m_idx;
      e.map_val  = 6'(m_val);
      sb.push_back(e);
   endtask

   initial begin
      RESET = 1'b0;
      STALL = 1'b0;
      rob_if.rob_head_valid      = 1'b0;
      rob_if.rob_head_done       = 1'b0;
      rob_if.rob_head_regwr      = 1'b0;
      rob_if.rob_head_archreg    = '0;
      rob_if.rob_head_physreg    = '0;
      rob_if.rob_head_mispredict = 1'b0;
      rob_if.rob_head_target     = '0;
      repeat (2) @(posedge clk);

      // reset state (RESET still low)
      //   v d rw arch phys mis tgt stall | ret free freg flush pc cnt map_idx map_val
      step(0,0,0, 0, 0, 0,0,0,  0,0, 0,0,0, 0,  5, 5);
      step(0,0,0, 0, 0, 0,0,0,  0,0, 0,0,0, 0, 31,31);
      RESET = 1'b1;
      // basic commit arch3 -> phys40
      step(1,1,1, 3,40, 0,0,0,  1,0, 0,0,0, 0,  3, 3);
      step(0,0,0, 0, 0, 0,0,0,  0,1, 3,0,0, 1,  3,40);
      // back-to-back same archreg: frees 4 then 42
      step(1,1,1, 4,42, 0,0,0,  1,0, 3,0,0, 1, -1, 0);
      step(1,1,1, 4,43, 0,0,0,  1,1, 4,0,0, 2,  4,42);
      step(0,0,0, 0, 0, 0,0,0,  0,1,42,0,0, 3,  4,43);
      // arch0 and regwr=0: counted, no free, no remap
      step(1,1,1, 0,33, 0,0,0,  1,0,42,0,0, 3,  0, 0);
      step(1,1,0, 9,34, 0,0,0,  1,0,42,0,0, 4,  0, 0);
      step(0,0,0, 0, 0, 0,0,0,  0,0,42,0,0, 5,  9, 9);
      // physreg equal to current mapping: no free
      step(1,1,1, 3,40, 0,0,0,  1,0,42,0,0, 5, -1, 0);
      // head valid but not done: waits
      step(1,0,1, 5,44, 0,0,0,  0,0,42,0,0, 6,  3,40);
      // mispredict arch7 -> phys50, then 2 hold cycles, commit on 3rd
      step(1,1,1, 7,50, 1,32'h0040_0100,0,  1,0,42,0,0, 6, -1, 0);
      step(1,1,1, 8,51, 0,0,0,  0,1, 7,1,32'h0040_0100, 7,  7,50);
      step(1,1,1, 8,51, 0,0,0,  0,0, 7,0,0, 7, -1, 0);
      step(1,1,1, 8,51, 0,0,0,  1,0, 7,0,0, 7, -1, 0);
      step(0,0,0, 0, 0, 0,0,0,  0,1, 8,0,0, 8,  8,51);
      // STALL in RUN blocks commit and freezes the count
      step(1,1,1,10,52, 0,0,1,  0,0, 8,0,0, 8, -1, 0);
      step(1,1,1,10,52, 0,0,1,  0,0, 8,0,0, 8, 10,10);
      step(1,1,1,10,52, 0,0,0,  1,0, 8,0,0, 8, -1, 0);
      step(0,0,0, 0, 0, 0,0,0,  0,1,10,0,0, 9, 10,52);
      // STALL during HOLD extends the hold; FLUSH still drops after one cycle
      step(1,1,1,11,53, 1,32'h0000_1234,0,  1,0,10,0,0, 9, -1, 0);
      step(1,1,1,12,54, 0,0,1,  0,1,11,1,32'h0000_1234,10, 11,53);
      step(1,1,1,12,54, 0,0,1,  0,0,11,0,0,10, -1, 0);
      step(1,1,1,12,54, 0,0,0,  0,0,11,0,0,10, -1, 0);
      step(1,1,1,12,54, 0,0,0,  0,0,11,0,0,10, -1, 0);
      step(1,1,1,12,54, 0,0,0,  1,0,11,0,0,10, -1, 0);
      step(0,0,0, 0, 0, 0,0,0,  0,1,12,0,0,11, 12,54);
      // reset asserted mid-HOLD returns straight to RUN
      step(1,1,1,13,55, 1,32'h0000_0040,0,  1,0,12,0,0,11, -1, 0);
      step(1,1,1,14,56, 0,0,0,  0,1,13,1,32'h0000_0040,12, 13,55);
      step(1,1,1,14,56, 0,0,0,  1,0, 0,0,0, 0, 13,13);
      RESET = 1'b0;
      #2;
      RESET = 1'b1;
      step(0,0,0, 0, 0, 0,0,0,  0,1,14,0,0, 1, 14,56);

      for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/retire_rrat.md
Name: retire_rrat

Overview:
- In-order commit stage at the ROB head, opposite end of the rename/free-list protocol.
- Retires at most one completed instruction per cycle and updates the retirement RAT (rrat_map).
- Returns the superseded physical register to the rename free list via rrat_free/rrat_free_reg.
- On a mispredicted head it raises FLUSH and a redirect PC, then holds off commits while the front end rebuilds from rrat_map.

Parameters:
- PHYS_W, 6, physical register index width (64 physical registers).
- FLUSH_HOLD, 2, cycles after a flush pulse during which no commit occurs (range 1-15).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- STALL  in  1  global stall; freezes commit and the hold counter.
- rob_head_valid  in  1  ROB head entry present.
- rob_head_done  in  1  head entry has completed execution.
- rob_head_regwr  in  1  head writes an architected register (reg-write or load).
- rob_head_archreg  in  5  architected destination.
- rob_head_physreg  in  PHYS_W  physical destination allocated at rename.
- rob_head_mispredict  in  1  head is a mispredicted branch/jump.
- rob_head_target  in  32  correct next PC for a mispredicted head.
- rob_retire  out  1  combinational pop strobe to the ROB for the current head.
- rrat_map  out  32 x PHYS_W  committed architected-to-physical map.
- rrat_free  out  1  registered one-cycle pulse: return a register to the free list.
- rrat_free_reg  out  PHYS_W  register being returned.
- FLUSH  out  1  registered one-cycle flush pulse.
- flush_pc  out  32  redirect PC, valid while FLUSH=1.
- retired_count  out  32  number of committed instructions.

Behaviour:
- Reset (RESET=0, asynchronous):
  - rrat_map[i]=i for i=0..31, consistent with the free list initially holding 32..63.
  - rrat_free=0, rrat_free_reg=0, FLUSH=0, flush_pc=0, retired_count=0.
  - State=RUN, hold counter=0.
  - Reset mid-hold returns to RUN immediately.
- States:
  - RUN: normal commit.
  - HOLD: counting down after a flush.
- Commit condition: commit = (state==RUN) & !STALL & rob_head_valid & rob_head_done. rob_retire = commit.
- On a commit edge:
  - retired_count increments by 1, wrapping at 2^32.
  - If rob_head_regwr & archreg!=0 & physreg!=rrat_map[archreg]: rrat_free<=1, rrat_free_reg<=old rrat_map[archreg], rrat_map[archreg]<=physreg. The old value is captured before the write in the same edge.
  - Otherwise rrat_free<=0 and rrat_map is unchanged. archreg 0 never remaps and never frees.
- Non-commit edge: rrat_free<=0; rrat_free_reg holds its last value.
- Mispredicted head:
  - It still commits, including its register update and free.
  - Same edge: FLUSH<=1, flush_pc<=rob_head_target, state<=HOLD, counter<=FLUSH_HOLD.
  - The updated rrat_map is visible in the same cycle FLUSH=1, so the free list and FRAT rebuild from the post-commit map.
  - The next edge clears FLUSH.
- HOLD:
  - No commit; rob_retire=0.
  - Counter decrements on each edge with !STALL; at 0, state<=RUN.
  - STALL freezes the counter; FLUSH still drops after one cycle.
- STALL in RUN: no commit; FLUSH and rrat_free still drop to 0 on the next edge, so they are never held high.
- Head present but not done: wait indefinitely; no outputs change except pulses clearing.
- Latency:
  - rob_retire to rrat_free/rrat_map update: 1 edge.
  - Maximum throughput: 1 commit per cycle, with back-to-back frees allowed.
- Same archreg committed on consecutive cycles: the second commit frees the physreg written by the first (map forwarding through the register is inherent).

Test Plan:
- Reset → rrat_map[5]=5, rrat_map[31]=31, all pulses 0, retired_count=0; assert RESET mid-HOLD → RUN next cycle.
- Head {valid,done,regwr,arch=3,phys=40} → rob_retire=1; next cycle rrat_free=1, rrat_free_reg=3, rrat_map[3]=40, retired_count=1.
- Back-to-back arch=3 with phys=40 then 41 → frees 3 then 40 on consecutive cycles; final rrat_map[3]=41.
- Head with arch=0 phys=33, or regwr=0 → commit counted, rrat_free stays 0, rrat_map unchanged.
- Mispredict head arch=7 phys=50 target=0x00400100 → same edge FLUSH=1, flush_pc=0x00400100, rrat_map[7]=50, rrat_free_reg=7; next 2 cycles rob_retire=0 even with a done head; commit resumes on the 3rd.
- STALL=1 with head done → no commit, rob_retire=0, retired_count frozen; STALL during HOLD extends the hold by the stalled cycles.
